// File: rtl/chan_mux_pkg.sv
// Shared definitions for the channel multiplexer: output-register state
// encoding and the transfer counter width.
package chan_mux_pkg;

  localparam int XFER_CNT_W = 16;

  // Output register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/chan_mux_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting channel at or after ptr,
// wrapping modulo NCH. Purely combinational.
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  // Channel index k positions after p, wrapped into 0..NCH-1.
  function automatic int wrap_idx(input int p, input int k);
    int s;
    s = p + k;
    return (s >= NCH) ? s - NCH : s;
  endfunction

  // Scan from ptr upward; the first requester found wins.
  always_comb begin
    // NOTE: every output gets a default before the scan so no latch is inferred.
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!grant_valid && req[wrap_idx(int'(ptr), k)]) begin
        grant       = SELW'(wrap_idx(int'(ptr), k));
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_mux.sv
// Channel multiplexer: selects one of NCH input channels (explicit select or
// round-robin) into a single registered output slot with valid/ready flow
// control, and counts completed output handshakes.
module chan_mux
  import chan_mux_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NCH   = 4,
  parameter  int MODE  = 0,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [SELW-1:0]       sel,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  state_t            state, state_nxt;
  logic [SELW-1:0]   grant;
  logic              grant_valid;
  logic              slot_free;
  logic              load;
  logic [WIDTH-1:0]  grant_data;

  assign out_valid = (state == FULL);
  assign slot_free = (state == EMPTY) || out_ready;
  assign load      = !reset && en && slot_free && grant_valid;

  if (MODE == 0) begin : g_sel
    // Explicit select: grant follows sel, valid only for an in-range channel.
    always_comb begin
      grant       = sel;
      grant_valid = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i)) grant_valid = in_valid[i];
      end
    end

    // Flag an out-of-range select whenever the block is enabled.
    always_ff @(posedge clk) begin
      // NOTE: all sequential state uses non-blocking assignment.
      if (reset) sel_err <= 1'b0;
      else       sel_err <= en && (int'(sel) >= NCH);
    end
  end else begin : g_rr
    logic [SELW-1:0] ptr;
    logic            unused_sel;

    assign unused_sel = ^sel;
    assign sel_err    = 1'b0;

    rr_arbiter #(
      .NCH  (NCH),
      .SELW (SELW)
    ) u_arb (
      .req         (in_valid),
      .ptr         (ptr),
      .grant       (grant),
      .grant_valid (grant_valid)
    );

    // Priority pointer moves to the channel after the last one loaded.
    always_ff @(posedge clk) begin
      if (reset)     ptr <= '0;
      else if (load) ptr <= (grant == SELW'(NCH - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Pick the granted channel's word and raise its ready on a load.
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load;
      end
    end
  end

  // Output slot state register.
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Fill on load; drain when the consumer takes the word and nothing replaces it.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (load) state_nxt = FULL;
               else if (out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Capture the granted word and its channel index on a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_ch   <= '0;
    end else if (load) begin
      out_data <= grant_data;
      out_ch   <= grant;
    end
  end

  // Count completed output handshakes; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)                       xfer_cnt <= '0;
    else if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 1'b1;
  end

endmodule

// File: tb/tb_chan_mux.sv
// Bench for chan_mux: three instances (select NCH=4, round-robin NCH=4,
// select NCH=3) checked every cycle against a behavioural model, with
// directed scenarios followed by randomized traffic and a counter wrap run.
module tb_chan_mux;

  typedef struct {
    bit          valid;
    logic [15:0] data;
    int          ch;
    logic [15:0] cnt;
    int          ptr;
  } model_t;

  localparam int MODE_OF [3] = '{0, 1, 0};
  localparam int NCH_OF  [3] = '{4, 4, 3};

  logic clk;
  logic rst;

  logic        drv_en    [3];
  logic [1:0]  drv_sel   [3];
  logic [3:0]  drv_valid [3];
  logic [63:0] drv_data  [3];
  logic        drv_ordy  [3];

  logic [3:0]  obs_rdy   [3];
  logic [15:0] obs_data  [3];
  logic [1:0]  obs_ch    [3];
  logic        obs_valid [3];
  logic        obs_err   [3];
  logic [15:0] obs_cnt   [3];

  model_t mdl [3];
  int     n_cmp = 0;
  int     n_bad = 0;

  logic [3:0]  a_rdy, b_rdy;
  logic [2:0]  c_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  chan_mux #(.WIDTH(16), .NCH(4), .MODE(0)) u_a (
    .clk(clk), .reset(rst), .en(drv_en[0]), .sel(drv_sel[0]),
    .in_data(drv_data[0]), .in_valid(drv_valid[0]), .in_ready(a_rdy),
    .out_data(obs_data[0]), .out_ch(obs_ch[0]), .out_valid(obs_valid[0]),
    .out_ready(drv_ordy[0]), .sel_err(obs_err[0]), .xfer_cnt(obs_cnt[0])
  );

  chan_mux #(.WIDTH(16), .NCH(4), .MODE(1)) u_b (
    .clk(clk), .reset(rst), .en(drv_en[1]), .sel(drv_sel[1]),
    .in_data(drv_data[1]), .in_valid(drv_valid[1]), .in_ready(b_rdy),
    .out_data(obs_data[1]), .out_ch(obs_ch[1]), .out_valid(obs_valid[1]),
    .out_ready(drv_ordy[1]), .sel_err(obs_err[1]), .xfer_cnt(obs_cnt[1])
  );

  chan_mux #(.WIDTH(16), .NCH(3), .MODE(0)) u_c (
    .clk(clk), .reset(rst), .en(drv_en[2]), .sel(drv_sel[2]),
    .in_data(drv_data[2][47:0]), .in_valid(drv_valid[2][2:0]), .in_ready(c_rdy),
    .out_data(obs_data[2]), .out_ch(obs_ch[2]), .out_valid(obs_valid[2]),
    .out_ready(drv_ordy[2]), .sel_err(obs_err[2]), .xfer_cnt(obs_cnt[2])
  );

  assign obs_rdy[0] = a_rdy;
  assign obs_rdy[1] = b_rdy;
  assign obs_rdy[2] = {1'b0, c_rdy};

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d: observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // One clock: check the combinational ready, advance the model, check the
  // registered outputs on the following falling edge.
  task automatic step();
    model_t nxt [3];
    bit     exp_err [3];
    #1;
    for (int d = 0; d < 3; d++) begin
      int         g;
      int         idx;
      bit         gv;
      bit         ld;
      logic [3:0] er;
      g  = 0;
      gv = 1'b0;
      if (MODE_OF[d] == 0) begin
        g  = int'(drv_sel[d]);
        gv = (g < NCH_OF[d]) && drv_valid[d][g];
      end else begin
        for (int k = 0; k < NCH_OF[d]; k++) begin
          idx = (mdl[d].ptr + k) % NCH_OF[d];
          if (!gv && drv_valid[d][idx]) begin
            gv = 1'b1;
            g  = idx;
          end
        end
      end
      ld = !rst && drv_en[d] && (!mdl[d].valid || drv_ordy[d]) && gv;
      er = ld ? (4'b0001 << g) : 4'b0000;
      check("in_ready", d, 32'(obs_rdy[d]), 32'(er));

      exp_err[d] = !rst && (MODE_OF[d] == 0) && drv_en[d] &&
                   (int'(drv_sel[d]) >= NCH_OF[d]);
      nxt[d] = mdl[d];
      if (rst) begin
        nxt[d].valid = 1'b0;
        nxt[d].data  = '0;
        nxt[d].ch    = 0;
        nxt[d].cnt   = '0;
        nxt[d].ptr   = 0;
      end else begin
        if (mdl[d].valid && drv_ordy[d]) begin
          nxt[d].cnt   = mdl[d].cnt + 16'd1;
          nxt[d].valid = 1'b0;
        end
        if (ld) begin
          nxt[d].valid = 1'b1;
          nxt[d].data  = drv_data[d][g*16 +: 16];
          nxt[d].ch    = g;
          if (MODE_OF[d] == 1) nxt[d].ptr = (g + 1) % NCH_OF[d];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      mdl[d] = nxt[d];
      check("out_valid", d, 32'(obs_valid[d]), 32'(mdl[d].valid));
      check("out_data",  d, 32'(obs_data[d]),  32'(mdl[d].data));
      check("out_ch",    d, 32'(obs_ch[d]),    32'(mdl[d].ch));
      check("xfer_cnt",  d, 32'(obs_cnt[d]),   32'(mdl[d].cnt));
      check("sel_err",   d, 32'(obs_err[d]),   32'(exp_err[d]));
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      drv_en[d]    = 1'b0;
      drv_sel[d]   = 2'd0;
      drv_valid[d] = 4'b0000;
      drv_data[d]  = 64'h0;
      drv_ordy[d]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq [5];
    for (int d = 0; d < 3; d++) begin
      mdl[d].valid = 1'b0;
      mdl[d].data  = '0;
      mdl[d].ch    = 0;
      mdl[d].cnt   = '0;
      mdl[d].ptr   = 0;
    end
    idle_all();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Explicit select: single word on channel 2 with the consumer ready.
    drv_en[0] = 1'b1; drv_sel[0] = 2'd2; drv_valid[0] = 4'b0100;
    drv_data[0] = 64'h1111_BEEF_3333_4444; drv_ordy[0] = 1'b1;
    step();
    check("sel_first_data", 0, 32'(obs_data[0]), 32'h0000_BEEF);
    check("sel_first_ch",   0, 32'(obs_ch[0]),   32'd2);
    drv_valid[0] = 4'b0000;
    step();
    check("sel_first_cnt",  0, 32'(obs_cnt[0]),  32'd1);

    // Backpressure: word must hold while the consumer stalls.
    do_reset();
    drv_valid[0] = 4'b0100; drv_ordy[0] = 1'b0;
    step();
    drv_data[0] = 64'h1111_1234_3333_4444;
    repeat (3) begin
      step();
      check("stall_data", 0, 32'(obs_data[0]), 32'h0000_BEEF);
    end
    drv_valid[0] = 4'b0000; drv_ordy[0] = 1'b1;
    step();
    check("stall_cnt",   0, 32'(obs_cnt[0]),   32'd1);
    check("stall_valid", 0, 32'(obs_valid[0]), 32'd0);
    idle_all();

    // Round-robin with every channel requesting.
    do_reset();
    exp_seq = '{0, 1, 2, 3, 0};
    drv_en[1] = 1'b1; drv_valid[1] = 4'b1111; drv_ordy[1] = 1'b1;
    drv_data[1] = 64'hDDDD_CCCC_BBBB_AAAA;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_all_ch", 1, 32'(obs_ch[1]), 32'(exp_seq[i]));
    end

    // Round-robin with channels 1 and 3 requesting, then en dropped.
    do_reset();
    exp_seq = '{1, 3, 1, 0, 0};
    drv_valid[1] = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rr_sparse_ch", 1, 32'(obs_ch[1]), 32'(exp_seq[i]));
    end
    drv_en[1] = 1'b0;
    step();
    check("rr_drain_valid", 1, 32'(obs_valid[1]), 32'd0);
    check("rr_drain_cnt",   1, 32'(obs_cnt[1]),   32'd3);
    step();
    check("rr_hold_valid",  1, 32'(obs_valid[1]), 32'd0);
    drv_en[1] = 1'b1;
    step();
    check("rr_resume_ch",   1, 32'(obs_ch[1]),    32'd3);
    idle_all();

    // Out-of-range select on the three-channel instance.
    do_reset();
    drv_en[2] = 1'b1; drv_sel[2] = 2'd3; drv_valid[2] = 4'b0111; drv_ordy[2] = 1'b1;
    drv_data[2] = 64'h0000_5555_6666_7777;
    step();
    check("oor_err",   2, 32'(obs_err[2]),   32'd1);
    check("oor_valid", 2, 32'(obs_valid[2]), 32'd0);
    drv_sel[2] = 2'd0;
    step();
    check("oor_clear", 2, 32'(obs_err[2]),   32'd0);
    idle_all();

    // Reset while full with a non-zero count discards the word.
    do_reset();
    drv_en[0] = 1'b1; drv_sel[0] = 2'd1; drv_valid[0] = 4'b0010; drv_ordy[0] = 1'b1;
    drv_data[0] = 64'h0000_0000_4321_0000;
    drv_en[1] = 1'b1; drv_valid[1] = 4'b1111; drv_ordy[1] = 1'b1;
    repeat (6) step();
    check("pre_rst_cnt", 0, 32'(obs_cnt[0]), 32'd5);
    drv_ordy[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_full_valid", 0, 32'(obs_valid[0]), 32'd0);
    check("rst_full_cnt",   0, 32'(obs_cnt[0]),   32'd0);
    step();
    check("rst_ptr_ch",     1, 32'(obs_ch[1]),    32'd0);
    idle_all();

    // Randomized traffic on all three instances.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 3; d++) begin
        drv_en[d]    = ($urandom % 4) != 0;
        drv_sel[d]   = 2'($urandom);
        drv_valid[d] = 4'($urandom);
        drv_data[d]  = {$urandom, $urandom};
        drv_ordy[d]  = ($urandom % 3) != 0;
      end
      rst = ($urandom % 50) == 0;
      step();
    end
    rst = 1'b0;
    idle_all();

    // Transfer counter wrap: one word per cycle for 65536 cycles.
    do_reset();
    drv_en[0] = 1'b1; drv_sel[0] = 2'd0; drv_valid[0] = 4'b0001; drv_ordy[0] = 1'b1;
    drv_data[0] = 64'h0000_0000_0000_00A5;
    repeat (65536) step();
    check("wrap_max",  0, 32'(obs_cnt[0]), 32'h0000_FFFF);
    step();
    check("wrap_zero", 0, 32'(obs_cnt[0]), 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chan_mux.md
CHAN_MUX -- requirements
Module: chan_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width per channel in bits (>=1).
REQ-002 SHALL have parameter NCH, default 4, number of input channels (2..16).
REQ-003 SHALL have parameter MODE, default 0; 0 = explicit select, 1 = round-robin arbitration.
REQ-004 SHALL derive SELW = max(1, ceil(log2(NCH))).
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 en  input  1  enable; 0 blocks new loads, never blocks draining.
REQ-009 sel  input  SELW  channel select, used only when MODE=0.
REQ-010 in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 in_valid  input  NCH  per-channel valid.
REQ-012 in_ready  output  NCH  per-channel ready, one-hot or zero, combinational.
REQ-013 out_data  output  WIDTH  registered selected data.
REQ-014 out_ch  output  SELW  channel index of out_data.
REQ-015 out_valid  output  1  output register holds data.
REQ-016 out_ready  input  1  downstream accepts out_data.
REQ-017 sel_err  output  1  registered one-cycle pulse: MODE=0, en=1, sel>=NCH.
REQ-018 xfer_cnt  output  16  count of completed output handshakes, wraps 0xFFFF->0x0000.

Function
REQ-019 Output register SHALL be a two-state FSM: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-020 slot_free = EMPTY or (FULL and out_ready); load = en and slot_free and grant_valid.
REQ-021 MODE=0: grant = sel, grant_valid = (sel<NCH) and in_valid[sel].
REQ-022 MODE=1: grant = first i with in_valid[i], scanning ptr, ptr+1, ... mod NCH; grant_valid = |in_valid.
REQ-023 On load, ptr SHALL become (grant+1) mod NCH next cycle; otherwise ptr holds; unused in MODE=0.
REQ-024 in_ready[grant] SHALL equal load; all other in_ready bits SHALL be 0.
REQ-025 On load, out_data/out_ch SHALL capture channel grant next cycle (latency 1), state -> FULL.
REQ-026 FULL and out_ready and not load -> EMPTY; FULL and out_ready and load -> FULL with new data (back-to-back, one word per cycle).
REQ-027 FULL and not out_ready: out_data, out_ch SHALL hold stable; in_ready all 0.
REQ-028 en=0: no load; FULL still drains on out_ready; ptr holds.
REQ-029 xfer_cnt SHALL increment by 1 on each cycle with out_valid and out_ready.
REQ-030 sel_err SHALL not depend on in_valid or slot_free; no load occurs for out-of-range sel.
REQ-031 out_data while EMPTY SHALL retain last loaded value (don't-care for checking).

Reset
REQ-032 reset SHALL force next cycle: EMPTY, out_valid=0, out_data=0, out_ch=0, sel_err=0, xfer_cnt=0, ptr=0.
REQ-033 reset SHALL dominate en, load and out_ready in the same cycle; in_ready SHALL be 0 while reset=1.
REQ-034 reset asserted while FULL SHALL discard held data without a handshake count.

Structure
REQ-035 Shared package SHALL hold FSM state encoding (EMPTY=0, FULL=1) and XFER_CNT_W=16.
REQ-036 Round-robin grant logic SHALL be one sub-module rr_arbiter (params NCH, SELW; in req, ptr; out grant, grant_valid).
REQ-037 MODE SHALL select via generate; the unused path SHALL not be instantiated.

Verification
REQ-038 MODE=0, NCH=4: reset, en=1, sel=2, in_valid=0100, ch2=0xBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xBEEF, out_ch=2, xfer_cnt increments after it.
REQ-039 MODE=0: sel=2 held, out_ready=0 for 3 cycles -> out_data stable 0xBEEF, in_ready=0000; then out_ready=1 -> one transfer, xfer_cnt=1.
REQ-040 MODE=1, all in_valid=1111, out_ready=1 -> out_ch sequence 0,1,2,3,0; one word per cycle.
REQ-041 MODE=1, in_valid=1010 from ptr=0 -> grants 1,3,1; en=0 mid-stream -> no loads, pending word drains.
REQ-042 MODE=0, NCH=3, sel=3 -> sel_err pulses, no load, in_ready=000.
REQ-043 reset while FULL and xfer_cnt=0x0005 -> out_valid=0, xfer_cnt=0, ptr=0 next cycle; 65536 transfers wrap xfer_cnt to 0.
